wb_host_initiator: RTL
======================

# wb_host_initiator

Wishbone classic single-transfer initiator: converts one command from a simple valid/ready command port into one Wishbone read or write cycle, then returns the result on a valid/ready response port. Sits on the host side of the user-project Wishbone bus and drives the same slave-side signals our project blocks receive (cyc, stb, we, sel, adr, dat). It lets logic-analyzer-driven or on-chip test logic exercise those blocks without the management core. A bounded wait-state timeout guarantees no transfer can hang the host.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of bus cycles waited for ack; 0 disables the timeout. Legal range is 0..65535.

Ports:
- wb_clk_i  in  1  sole clock; all logic is on the rising edge.
- wb_rst_i  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_dat  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  1 = transfer aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge from the slave.
- wbm_dat_i  in  32  Wishbone read data from the slave.
- busy  out  1  high in BUS or RESP.

## Operation
- States:
  - IDLE (reset state).
  - BUS: Wishbone cycle in progress.
  - RESP: response held for the consumer.
- Command acceptance:
  - In IDLE, a command is accepted on an edge where cmd_valid and cmd_ready are both high.
  - On that edge, cmd_we, cmd_adr, cmd_dat and cmd_sel are registered into the wbm_* outputs. The state moves to BUS and the wait counter clears to 0.
- BUS state:
  - wbm_cyc_o and wbm_stb_o are both 1, driven from registers with no combinational path from any input.
  - wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o stay stable for the whole cycle.
- Ack in BUS:
  - On an edge with wbm_ack_i=1: cyc and stb go to 0.
  - For a read, rsp_dat captures wbm_dat_i; for a write, rsp_dat is 0.
  - rsp_err goes to 0 and the state moves to RESP.
- No ack in BUS:
  - On an edge with wbm_ack_i=0, the wait counter (16 bits) increments.
  - If TIMEOUT≠0 and the counter equals TIMEOUT-1 on that edge: cyc and stb go to 0, rsp_dat goes to 0, rsp_err goes to 1, and the state moves to RESP.
  - So the bus is held for exactly TIMEOUT cycles.
- RESP state:
  - rsp_valid is 1 and rsp_dat/rsp_err are stable.
  - On an edge with rsp_ready=1, the state moves to IDLE and rsp_valid goes to 0.
- Ignored inputs:
  - wbm_ack_i is ignored outside BUS (late or spurious acks have no effect).
  - cmd_valid is ignored outside IDLE.
- When ack and the timeout condition occur on the same edge, ack wins: rsp_err=0 and the data is captured.
- After the cycle ends, wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o hold their last values; only cyc and stb return to 0.

## Timing
- Reset values, applied immediately on wb_rst_i rising, with no clock needed:
  - state=IDLE.
  - cyc, stb, we and rsp_valid = 0; rsp_err = 0.
  - adr, dat, sel and rsp_dat = 0.
  - busy = 0; cmd_ready = 1 once reset is released.
- Reset mid-transfer (in BUS or RESP): the bus cycle is aborted at once and no response is produced.
- Command accepted at edge N:
  - cyc and stb are high from N to N+1.
  - A slave that acks in the first bus cycle is sampled at edge N+1, so rsp_valid is high after N+1.
  - With rsp_ready held at 1, the state returns to IDLE at N+2 and cmd_ready is high after N+2.
  - Minimum spacing between accepted commands is therefore 3 clocks.
- Each wait state the slave inserts adds one clock.
- Timeout (ack never arrives): cyc is high for exactly TIMEOUT clocks, and rsp_valid rises on the edge that drops cyc.
- TIMEOUT=0: BUS waits indefinitely.
- Only one transfer is ever outstanding; there is no pipelined/burst mode and no err/rty support.

## Test plan
- Write, zero-wait slave: cmd_we=1, adr=0x3000_0004, dat=0x1234_5678, sel=0xF, ack in the first bus cycle.
  - Expect cyc high for 1 clock with wbm_dat_o=0x1234_5678.
  - Expect rsp_valid one clock later with rsp_err=0 and rsp_dat=0.
- Read, 3 wait states: slave returns 0xCAFE_F00D.
  - Expect cyc high for 4 clocks and rsp_dat=0xCAFE_F00D with rsp_err=0.
  - Expect adr, sel and we unchanged throughout the cycle.
- Timeout: TIMEOUT=8, slave never acks.
  - Expect cyc high for exactly 8 clocks, then rsp_err=1 and rsp_dat=0.
  - A spurious ack injected 2 clocks later has no effect.
- Backpressure: hold rsp_ready=0 for 5 clocks after a read completes.
  - Expect rsp_valid and rsp_dat stable, cmd_ready=0, and a pending cmd_valid not accepted until after the rsp_ready edge.
- Reset mid-cycle: assert wb_rst_i asynchronously (between edges) during wait state 2 of a read.
  - Expect cyc, stb and rsp_valid to fall before the next edge.
  - After release, expect cmd_ready=1 and a fresh write completing normally.
- Ack/timeout collision: TIMEOUT=4 and ack arriving in the 4th bus clock.
  - Expect rsp_err=0 and read data captured.

Source files
------------

// File: rtl/wb_host_initiator.sv
// wb_host_initiator
//
// Turns one command from a valid/ready command port into one classic
// single-transfer Wishbone read or write. It then returns the result on a
// valid/ready response port. A bounded wait-state timeout ensures that a
// silent slave cannot hang the host.
//
// Parameters:
//   TIMEOUT   bus clocks to wait for ack before aborting (0 = wait forever),
//             legal range 0..65535
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_we/adr/dat/sel        command payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_dat, rsp_err          read data (0 for writes/timeouts), timeout flag
//   wbm_*                     Wishbone initiator signals
//   busy                      transfer or response outstanding
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// BUS   | Wishbone cycle in progress, cyc/stb high
// RESP  | response held until the consumer takes it

module wb_host_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    // Counter value seen on the last permitted bus clock; the subtraction
    // only matters when the timeout is enabled.
    localparam logic [15:0] WAIT_LAST  = TIMEOUT_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    logic [15:0] wait_cnt;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= BUS;
                        wait_cnt  <= 16'd0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a same-edge timeout.
                    if (wbm_ack_i) begin
                        state     <= RESP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                            state     <= RESP;
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_dat   <= 32'd0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
